// File: rtl/torture_trace_serializer.sv
// Commit trace serializer: captures up to NUM_LANES commits per cycle into a
// multi-write single-read FIFO and streams one sequence-tagged record per cycle.

module tts_lane_pack #(
  parameter int PC_W  = 40,
  parameter int XLEN  = 64,
  parameter int REC_W = PC_W + 32 + 5 + 1 + XLEN + 1 + XLEN + 2
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      inst,
  input  logic [4:0]       reg_dst,
  input  logic             reg_wr_valid,
  input  logic [XLEN-1:0]  data,
  input  logic             xcpt,
  input  logic [XLEN-1:0]  xcpt_cause,
  input  logic [1:0]       priv,
  output logic [REC_W-1:0] rec
);
  assign rec = {priv, xcpt_cause, xcpt, data, reg_wr_valid, reg_dst, inst, pc};
endmodule

module torture_trace_serializer #(
  parameter  int NUM_LANES = 2,
  parameter  int PC_W      = 40,
  parameter  int XLEN      = 64,
  parameter  int DEPTH     = 8,
  parameter  int SEQ_W     = 16,
  localparam int REC_W     = PC_W + 32 + 5 + 1 + XLEN + 1 + XLEN + 2,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_en,
  input  logic [NUM_LANES-1:0]      commit_valid,
  input  logic [NUM_LANES-1:0]      reg_wr_valid,
  input  logic [NUM_LANES*PC_W-1:0] pc,
  input  logic [NUM_LANES*32-1:0]   inst,
  input  logic [NUM_LANES*5-1:0]    reg_dst,
  input  logic [NUM_LANES*XLEN-1:0] data,
  input  logic [NUM_LANES-1:0]      xcpt,
  input  logic [NUM_LANES*XLEN-1:0] xcpt_cause,
  input  logic [NUM_LANES*2-1:0]    csr_priv_lvl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REC_W-1:0]          out_rec,
  output logic [LANE_W-1:0]         out_lane,
  output logic [SEQ_W-1:0]          out_seq,
  output logic                      overflow,
  input  logic                      overflow_clr,
  output logic [31:0]               drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REC_W-1:0]  rec;
    logic [LANE_W-1:0] lane;
    logic [SEQ_W-1:0]  seq;
  } entry_t;

  logic [NUM_LANES-1:0][REC_W-1:0] lane_rec;
  logic [NUM_LANES-1:0][CNT_W-1:0] lane_off;
  logic [NUM_LANES-1:0][PTR_W-1:0] lane_slot;
  logic [NUM_LANES-1:0]            cap;
  logic [CNT_W-1:0]                k, count, free;
  logic [PTR_W-1:0]                wr_ptr, rd_ptr;
  logic [SEQ_W-1:0]                seq;
  logic [32:0]                     drop_sum;
  logic                            accept, drop, pop;
  entry_t                          mem [DEPTH];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tts_lane_pack #(.PC_W(PC_W), .XLEN(XLEN)) u_pack (
      .pc           (pc[g*PC_W +: PC_W]),
      .inst         (inst[g*32 +: 32]),
      .reg_dst      (reg_dst[g*5 +: 5]),
      .reg_wr_valid (reg_wr_valid[g]),
      .data         (data[g*XLEN +: XLEN]),
      .xcpt         (xcpt[g]),
      .xcpt_cause   (xcpt_cause[g*XLEN +: XLEN]),
      .priv         (csr_priv_lvl[g*2 +: 2]),
      .rec          (lane_rec[g])
    );
  end

  assign cap = commit_valid & {NUM_LANES{trace_en}};

  // Each captured lane lands at wr_ptr + (number of lower captured lanes).
  always_comb begin
    k = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_off[i]  = k;
      lane_slot[i] = wr_ptr + PTR_W'(lane_off[i]);
      k            = k + CNT_W'(cap[i]);
    end
  end

  // Space is judged on start-of-cycle count; a same-cycle pop does not help.
  assign free      = CNT_W'(DEPTH) - count;
  assign accept    = (k <= free);
  assign drop      = !accept;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign drop_sum  = {1'b0, drop_cnt} + 33'(k);

  assign out_rec  = mem[rd_ptr].rec;
  assign out_lane = mem[rd_ptr].lane;
  assign out_seq  = mem[rd_ptr].seq;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (cap[i]) begin
          mem[lane_slot[i]].rec  <= lane_rec[i];
          mem[lane_slot[i]].lane <= LANE_W'(i);
          mem[lane_slot[i]].seq  <= seq + SEQ_W'(lane_off[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      count  <= count + (accept ? k : CNT_W'(0)) - CNT_W'(pop);
      wr_ptr <= wr_ptr + (accept ? PTR_W'(k) : PTR_W'(0));
      rd_ptr <= rd_ptr + PTR_W'(pop);
      // Dropped records still consume sequence numbers so the sink sees the gap.
      seq    <= seq + SEQ_W'(k);
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_torture_trace_serializer.sv
// Directed bench for torture_trace_serializer (NUM_LANES=2, DEPTH=8, SEQ_W=16).

module tb_torture_trace_serializer;
  localparam int NL = 2, PC_W = 40, XLEN = 64;
  localparam int REC_W = PC_W + 32 + 5 + 1 + XLEN + 1 + XLEN + 2;

  logic              clk = 1'b0;
  logic              rst, trace_en, out_ready, overflow_clr;
  logic [NL-1:0]     commit_valid, reg_wr_valid, xcpt;
  logic [NL*PC_W-1:0] pc;
  logic [NL*32-1:0]  inst;
  logic [NL*5-1:0]   reg_dst;
  logic [NL*XLEN-1:0] data, xcpt_cause;
  logic [NL*2-1:0]   csr_priv_lvl;
  logic              out_valid, overflow;
  logic [REC_W-1:0]  out_rec, exp_rec, prev_rec;
  logic [0:0]        out_lane;
  logic [15:0]       out_seq, exp_seq, prev_seq;
  logic [31:0]       drop_cnt;
  int checks = 0, failures = 0;

  torture_trace_serializer u_dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .commit_valid(commit_valid),
    .reg_wr_valid(reg_wr_valid), .pc(pc), .inst(inst), .reg_dst(reg_dst),
    .data(data), .xcpt(xcpt), .xcpt_cause(xcpt_cause), .csr_priv_lvl(csr_priv_lvl),
    .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .out_lane(out_lane), .out_seq(out_seq), .overflow(overflow),
    .overflow_clr(overflow_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int n, pops;
    logic prev_stall;
    rst = 1'b0; trace_en = 1'b1; out_ready = 1'b1; overflow_clr = 1'b0;
    commit_valid = '0; reg_wr_valid = '0; xcpt = '0; pc = '0; inst = '0;
    reg_dst = '0; data = '0; xcpt_cause = '0; csr_priv_lvl = '0;
    tick(); tick();
    rst = 1'b1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);

    // Capture disabled: nothing enters, seq does not advance
    trace_en = 1'b0; commit_valid = 2'b11;
    tick();
    commit_valid = '0; trace_en = 1'b1;
    chk("trace_en_off_valid", 64'(out_valid), 64'd0);

    // Single lane, empty FIFO, full record packing
    commit_valid = 2'b01; pc[39:0] = 40'h80000000; inst[31:0] = 32'h13;
    reg_dst[4:0] = 5'd7; reg_wr_valid = 2'b01; data[63:0] = 64'hDEAD_BEEF;
    xcpt = 2'b01; xcpt_cause[63:0] = 64'hCAFE; csr_priv_lvl[1:0] = 2'b11;
    exp_rec = {2'b11, 64'hCAFE, 1'b1, 64'hDEAD_BEEF, 1'b1, 5'd7, 32'h13, 40'h80000000};
    tick();
    commit_valid = '0; reg_wr_valid = '0; xcpt = '0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_pc", 64'(out_rec[39:0]), 64'h80000000);
    chk("single_lane", 64'(out_lane), 64'd0);
    chk("single_seq", 64'(out_seq), 64'd0);
    checks++;
    assert (out_rec === exp_rec) else begin
      failures++;
      $error("FAIL single_rec observed=%0h expected=%0h", out_rec, exp_rec);
    end
    tick();
    chk("single_drained", 64'(out_valid), 64'd0);

    // Dual commit ordering
    do_reset();
    commit_valid = 2'b11; pc[39:0] = 40'h100; pc[79:40] = 40'h104;
    tick();
    commit_valid = '0;
    chk("dual0_pc", 64'(out_rec[39:0]), 64'h100);
    chk("dual0_seq", 64'(out_seq), 64'd0);
    chk("dual0_lane", 64'(out_lane), 64'd0);
    tick();
    chk("dual1_pc", 64'(out_rec[39:0]), 64'h104);
    chk("dual1_seq", 64'(out_seq), 64'd1);
    chk("dual1_lane", 64'(out_lane), 64'd1);
    tick();
    chk("dual_drained", 64'(out_valid), 64'd0);

    // Overflow: fill 8, drop the 5th dual group (clear in same cycle loses)
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      commit_valid = 2'b11;
      pc[39:0] = 40'h200 + 40'(8 * c); pc[79:40] = 40'h204 + 40'(8 * c);
      tick();
    end
    chk("full_no_overflow", 64'(overflow), 64'd0);
    overflow_clr = 1'b1; pc[39:0] = 40'hBAD; pc[79:40] = 40'hBAD;
    tick();
    overflow_clr = 1'b0; commit_valid = '0;
    chk("ovf_set_wins", 64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain_seq", 64'(out_seq), 64'(i));
      chk("ovf_drain_pc", 64'(out_rec[39:0]), 64'h200 + 64'(4 * i));
      tick();
    end
    chk("ovf_empty", 64'(out_valid), 64'd0);
    commit_valid = 2'b01; pc[39:0] = 40'h300;
    tick();
    commit_valid = '0;
    chk("ovf_gap_seq", 64'(out_seq), 64'd10);
    tick();

    // No partial accept: count=7, dual commit with simultaneous pop
    do_reset();
    out_ready = 1'b0;
    commit_valid = 2'b11; tick(); tick(); tick();
    commit_valid = 2'b01; tick();
    commit_valid = 2'b11; out_ready = 1'b1;
    tick();
    commit_valid = '0;
    chk("np_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("np_overflow", 64'(overflow), 64'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        chk("np_seq", 64'(out_seq), 64'(1 + n));
        n++;
        tick();
      end
    end
    chk("np_remaining", 64'(n), 64'd6);
    commit_valid = 2'b01;
    tick();
    commit_valid = '0;
    chk("np_next_seq", 64'(out_seq), 64'd9);
    tick();

    // Push seq near wrap with dropped groups, then drain
    do_reset();
    out_ready = 1'b0; commit_valid = 2'b11;
    for (int i = 0; i < 4 + 32762; i++) tick();
    commit_valid = '0;
    chk("wrap_drop_cnt", 64'(drop_cnt), 64'd65524);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_empty", 64'(out_valid), 64'd0);

    // Toggling backpressure across the seq wrap
    exp_seq = 16'hFFFC; pops = 0; prev_stall = 1'b0; prev_rec = '0; prev_seq = '0;
    for (int c = 0; c < 40; c++) begin
      out_ready = c[0];
      if (out_valid && prev_stall) begin
        chk("bp_hold_seq", 64'(out_seq), 64'(prev_seq));
        chk("bp_hold_pc", 64'(out_rec[39:0]), 64'(prev_rec[39:0]));
      end
      if (out_valid && out_ready) begin
        chk("bp_pop_seq", 64'(out_seq), 64'(exp_seq));
        chk("bp_pop_pc", 64'(out_rec[39:0]), 64'(pops));
        exp_seq = exp_seq + 16'd1;
        pops++;
      end
      prev_stall = out_valid && !out_ready;
      prev_rec = out_rec; prev_seq = out_seq;
      commit_valid = (c < 12) ? 2'b01 : 2'b00;
      pc[39:0] = 40'(c);
      tick();
    end
    commit_valid = '0;
    chk("bp_pop_count", 64'(pops), 64'd12);
    chk("bp_final_seq", 64'(exp_seq), 64'd8);
    chk("bp_drop_unchanged", 64'(drop_cnt), 64'd65524);

    // Overflow clear, then reset with entries buffered
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_keeps_drop_cnt", 64'(drop_cnt), 64'd65524);
    out_ready = 1'b0;
    commit_valid = 2'b11; tick(); tick();
    commit_valid = 2'b01; tick();
    commit_valid = '0;
    chk("buffered_valid", 64'(out_valid), 64'd1);
    do_reset();
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_drop_cnt", 64'(drop_cnt), 64'd0);
    commit_valid = 2'b01;
    tick();
    commit_valid = '0;
    chk("rst_mid_next_seq", 64'(out_seq), 64'd0);
    chk("rst_mid_next_valid", 64'(out_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/torture_trace_serializer.md
Name: torture_trace_serializer

Overview:
- Synthesizable, parametrised successor to the single-lane behavioural commit dumper.
- Captures up to NUM_LANES committed instructions per cycle from writeback and buffers them in a multi-write, single-read FIFO.
- Emits one trace record per cycle on a valid/ready stream toward the torture trace sink (DPI shim in simulation, debug UART/DMA on FPGA).
- Tags each record with a sequence number so the sink can detect drops.

Parameters:
- NUM_LANES, 2, commit lanes sampled per cycle (1..4).
- PC_W, 40, captured PC width (low bits of the 64-bit PC).
- XLEN, 64, data and cause width.
- DEPTH, 8, FIFO entries; power of two, >= NUM_LANES.
- SEQ_W, 16, sequence counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- trace_en  in  1  capture enable.
- commit_valid  in  NUM_LANES  per-lane commit strobe.
- reg_wr_valid  in  NUM_LANES  per-lane register write flag.
- pc  in  NUM_LANES*PC_W  per-lane PC.
- inst  in  NUM_LANES*32  per-lane instruction.
- reg_dst  in  NUM_LANES*5  per-lane destination register.
- data  in  NUM_LANES*XLEN  per-lane writeback data.
- xcpt  in  NUM_LANES  per-lane exception flag.
- xcpt_cause  in  NUM_LANES*XLEN  per-lane cause.
- csr_priv_lvl  in  NUM_LANES*2  per-lane next privilege level.
- out_valid  out  1  record available.
- out_ready  in  1  sink accepts.
- out_rec  out  REC_W  record {priv, xcpt_cause, xcpt, data, reg_wr_valid, reg_dst, inst, pc}; REC_W = PC_W+32+5+1+XLEN+1+XLEN+2.
- out_lane  out  $clog2(NUM_LANES) (min 1)  originating lane.
- out_seq  out  SEQ_W  record sequence number.
- overflow  out  1  sticky drop flag.
- overflow_clr  in  1  clears the overflow flag.
- drop_cnt  out  32  count of dropped records.

Behaviour:
- Reset (rst==0 at posedge):
  - FIFO empties: count=0, pointers=0.
  - out_valid=0, out_seq=0, seq counter=0, overflow=0, drop_cnt=0.
  - Reset mid-operation discards all buffered records.
- Capture group:
  - k = popcount(commit_valid & {NUM_LANES{trace_en}}).
  - trace_en==0: k=0, nothing captured, seq does not advance.
- Accept rule:
  - Accept if k <= DEPTH - count, using count at the start of the cycle. A pop in the same cycle does not free space for that cycle's writes.
  - On accept, valid lanes are written in ascending lane order (lowest lane is oldest) at consecutive slots from wr_ptr, with sequential seq values seq, seq+1, ….
  - Lane index is stored alongside each record.
- Drop:
  - If k > DEPTH - count, the whole group is dropped. No partial writes.
  - overflow is set to 1.
  - drop_cnt increases by k, saturating at 0xFFFFFFFF.
  - The seq counter still advances by k, so the sink sees a gap.
- Seq counter wraps modulo 2^SEQ_W.
- Read side:
  - out_valid = (count != 0).
  - out_rec, out_lane and out_seq show the head entry combinationally from FIFO storage.
  - Pop occurs when out_valid & out_ready. Outputs stay stable while out_valid & !out_ready.
- Count update: count_next = count + accepted_k - pop. Both pointers wrap modulo DEPTH.
- overflow_clr:
  - Clears overflow.
  - If a drop occurs in the same cycle, set wins and overflow stays 1.
  - drop_cnt is only cleared by reset.
- Latency: a record committed in cycle t is visible on out_* in cycle t+1 at the earliest (empty FIFO).

Test Plan:
- Single lane, empty FIFO: reset, then lane0 commits pc=0x80000000, inst=0x00000013, out_ready=1 -> cycle t+1: out_valid=1, out_rec.pc=0x80000000, out_lane=0, out_seq=0; cycle t+2: out_valid=0.
- Dual commit ordering: lanes 0 and 1 commit pc=0x100/0x104 in the same cycle -> emitted in order: 0x100 (seq 0, lane 0), then 0x104 (seq 1, lane 1) on consecutive cycles.
- Overflow: DEPTH=8, out_ready=0, 4 cycles of dual commit fill the FIFO (count=8); a 5th dual commit -> dropped; overflow=1, drop_cnt=2. Then out_ready=1 and a new commit -> after draining seqs 0..7, the new record carries seq=10.
- No partial accept: count=7, dual commit, simultaneous pop -> group dropped; count=6, drop_cnt=2.
- Backpressure hold: out_ready toggled 0/1 every cycle -> out_rec/out_seq stable while stalled; no duplicate or lost seq values; seq wraps 0xFFFF->0x0000 across a long run.
- Reset and clear: overflow set, then overflow_clr=1 -> overflow=0. rst=0 for one cycle with 5 entries buffered -> out_valid=0, drop_cnt=0, next record has seq=0.
